b06_irq_requester: RTL and testbench

Initiator side of the b06 interrupt handshake. Accepts interrupt requests from a host and buffers them in a small FIFO. Presents each request to the b06 handler on `eql`/`cont_eql` and holds it until the handler answers on `ackout`. Sits directly in front of the b06 handler in the benchmark harness, so the handler can be exercised by a real sequential source instead of free inputs.

---
 rtl/b06_req_pkg.sv | 20 ++
 rtl/b06_req_wdog.sv | 35 +++
 rtl/b06_irq_requester.sv | 176 +++++++++++++++++
 tb/tb_b06_irq_requester.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/b06_req_pkg.sv
// Shared types and constants for the b06 interrupt requester.
package b06_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PTR_W   = $clog2(DEF_DEPTH);

  // Pointer width for a FIFO of the given depth (never narrower than one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/b06_req_wdog.sv
// Watchdog for the REQ phase: a loadable down-counter.
// clear reloads it with TIMEOUT-1; enable counts one REQ cycle down.
// expired is high once TIMEOUT REQ cycles have elapsed since the last clear.
module b06_req_wdog
  import b06_req_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_reg;

  // Reload on REQ entry, then count down and saturate at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= LOAD;
    end else if (enable && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - ONE;
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/b06_irq_requester.sv
// Initiator side of the b06 interrupt handshake: request FIFO plus a
// Moore FSM driving eql/cont_eql toward the b06 handler.
// Build option B06_REQ_TIMEOUT_EN: when defined, a watchdog aborts a REQ
// phase after TIMEOUT cycles without ackout; otherwise REQ waits forever
// and timeout_err is constant 0.
module b06_irq_requester
  import b06_req_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             req_code,
  input  logic             ackout,
  output logic             eql,
  output logic             cont_eql,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             overflow,
  output logic [CNT_W-1:0] req_count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic              fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;

  state_t            state_reg;
  logic              success_reg;

  assign fifo_empty = (fill_reg == '0);
  assign fifo_full  = (fill_reg == FILL_MAX);
  // IDLE pops whenever something is queued; a pop frees a slot for a
  // same-cycle push even when the FIFO is full.
  assign pop  = (state_reg == ST_IDLE) && !fifo_empty;
  assign push = start && (!fifo_full || pop);

  // Occupancy after this edge.
  always_comb begin
    fill_next = fill_reg;
    if (push && !pop) begin
      fill_next = fill_reg + FILL_ONE;
    end else if (pop && !push) begin
      fill_next = fill_reg - FILL_ONE;
    end
  end

  // Request storage; the head is read out registered into cont_eql.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= req_code;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      fill_reg <= fill_next;
      if (start && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef B06_REQ_TIMEOUT_EN
  logic wdog_expired;

  b06_req_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (pop),
    .enable  (state_reg == ST_REQ),
    .expired (wdog_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_err    = 1'b0;
`endif

  // Handshake FSM with registered Moore outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      success_reg <= 1'b0;
      eql         <= 1'b0;
      cont_eql    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_count   <= '0;
`ifdef B06_REQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef B06_REQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            state_reg   <= ST_REQ;
            eql         <= 1'b1;
            cont_eql    <= fifo_mem[rd_ptr_reg];
            success_reg <= 1'b0;
            busy        <= 1'b1;
          end else begin
            busy <= (fill_next != '0);
          end
        end
        ST_REQ: begin
          busy <= 1'b1;
          // ackout wins over a watchdog expiring on the same edge.
          if (ackout) begin
            state_reg   <= ST_REL;
            eql         <= 1'b0;
            success_reg <= 1'b1;
          end
`ifdef B06_REQ_TIMEOUT_EN
          else if (wdog_expired) begin
            state_reg   <= ST_REL;
            eql         <= 1'b0;
            timeout_err <= 1'b1;
          end
`endif
        end
        ST_REL: begin
          if (!ackout) begin
            state_reg <= ST_IDLE;
            busy      <= (fill_next != '0);
            if (success_reg) begin
              done      <= 1'b1;
              req_count <= req_count + CNT_ONE;
            end
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          eql       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b06_irq_requester.sv
// Scoreboard bench for b06_irq_requester. The reference model treats the
// requester as a queue feeding a single server whose handshake duration
// follows from the responder plan chosen at pop time.
module tb_b06_irq_requester;

  localparam int DEPTH = 4;
  localparam int TO    = 15;
  localparam int CW    = 2;
`ifdef B06_REQ_TIMEOUT_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          req_code = 1'b0;
  logic          ackout = 1'b0;
  logic          eql, cont_eql, busy, done, timeout_err, overflow;
  logic [CW-1:0] req_count;

  b06_irq_requester #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .req_code    (req_code),
    .ackout      (ackout),
    .eql         (eql),
    .cont_eql    (cont_eql),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .overflow    (overflow),
    .req_count   (req_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int code; int edge_no; int len; } rise_t;
  typedef struct { bit ok; int cnt; int edge_no; } out_t;

  rise_t rise_q[$];
  out_t  out_q[$];
  int    q[$];
  int    srv_end = 0, pp = -100, pd = -1, ph = 0, m_cnt = 0;
  bit    m_ovf = 1'b0, m_busy = 1'b0, flush = 1'b0;
  bit    s_held = 1'b0, c_held = 1'b0, r_held = 1'b1;
  int    force_d = -9, force_h = 1;
  int    checks = 0, fails = 0;
  int    n_hs = 0, cnt_before = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: apply the inputs that were sampled at edge number cyc.
  task automatic model_edge();
    int e, code, d, h, r;
    bit pop, full;
    e = cyc;
    if (r_held) begin
      q.delete(); rise_q.delete(); out_q.delete();
      srv_end = e; pd = -1; pp = -100; m_cnt = 0;
      m_ovf = 1'b0; m_busy = 1'b0; flush = 1'b1;
      return;
    end
    pop  = (e > srv_end) && (q.size() > 0);
    full = (q.size() == DEPTH);
    if (pop) begin
      code = q.pop_front();
      if (force_d != -9) begin
        d = force_d; h = force_h;
      end else begin
        r = $urandom_range(0, 9);
        h = $urandom_range(1, 3);
        if (r == 0)      d = WDOG ? -1 : TO + 3;
        else if (r == 1) d = TO - 1;
        else             d = $urandom_range(0, 4);
      end
      pp = e; pd = d; ph = h;
      if (d < 0) begin
        srv_end = e + TO + 1;
        rise_q.push_back('{code, e, TO});
        out_q.push_back('{1'b0, m_cnt, e + TO});
      end else begin
        srv_end = e + d + h + 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
        rise_q.push_back('{code, e, d + 1});
        out_q.push_back('{1'b1, m_cnt, srv_end});
      end
    end
    if (s_held) begin
      if (!full || pop) q.push_back(int'(c_held));
      else m_ovf = 1'b1;
    end
    m_busy = (e < srv_end) || (q.size() > 0);
  endtask

  // One cycle: model the edge just passed, then drive inputs for the next one.
  task automatic step(input bit s, input bit c, input bit r);
    @(negedge clock);
    model_edge();
    s_held = s; c_held = c; r_held = r;
    start = s; req_code = c; reset = r;
    ackout = (pd >= 0) && (cyc + 1 >= pp + pd + 1) && (cyc + 1 <= pp + pd + ph);
  endtask

  task automatic drain();
    repeat (2) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400 && !((cyc > srv_end) && (q.size() == 0)); i++)
      step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or completion.
  bit    prev_eql = 1'b0, have_cur = 1'b0;
  int    eql_len = 0;
  rise_t cur;
  out_t  oc;
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (flush) begin
        flush = 1'b0; prev_eql = 1'b0; eql_len = 0; have_cur = 1'b0;
      end else begin
        if (eql && !prev_eql) begin
          chk("eql_rise_pending", int'(rise_q.size() > 0), 1);
          if (rise_q.size() > 0) begin
            cur = rise_q.pop_front();
            have_cur = 1'b1;
            chk("cont_eql", cont_eql, cur.code);
            chk("eql_rise_cycle", cyc, cur.edge_no);
          end
          eql_len = 0;
        end
        if (eql) eql_len++;
        if (!eql && prev_eql && have_cur) begin
          chk("eql_high_cycles", eql_len, cur.len);
          have_cur = 1'b0;
        end
        if (done || timeout_err) begin
          chk("completion_pending", int'(out_q.size() > 0), 1);
          if (out_q.size() > 0) begin
            oc = out_q.pop_front();
            n_hs++;
            chk("done", done, oc.ok);
            chk("timeout_err", timeout_err, !oc.ok);
            chk("req_count", req_count, oc.cnt);
            chk("completion_cycle", cyc, oc.edge_no);
            $display("handshake %0d: code=%0d ok=%0d req_count=%0d cycle=%0d",
                     n_hs, cont_eql, done, req_count, cyc);
          end
        end
        prev_eql = eql;
      end
      chk("busy", busy, m_busy);
      chk("overflow", overflow, m_ovf);
    end
  end

  initial begin
    // Reset values
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_eql", eql, 0);
    chk("rst_cont_eql", cont_eql, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_req_count", req_count, 0);
    step(1'b0, 1'b0, 1'b0);

    // Single request, code 1
    force_d = 2; force_h = 2;
    step(1'b1, 1'b1, 1'b0);
    drain();
    chk("single_req_count", req_count, 1);

    // Burst of five while the server is busy: the fifth start is dropped
    force_d = 10; force_h = 1;
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("burst_overflow", overflow, 1);
    drain();

    // Push coinciding with the pop of a full FIFO
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    force_d = 6; force_h = 1;
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && (cyc + 2 < srv_end + 1); i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("simul_no_overflow", overflow, 0);
    drain();
    chk("simul_all_served", q.size() + rise_q.size() + out_q.size(), 0);

    // No acknowledge: watchdog abort, or an indefinite wait without it
    cnt_before = int'(req_count);
    force_d = WDOG ? -1 : TO + 5;
    force_h = 1;
    step(1'b1, 1'b0, 1'b0);
    drain();
    chk("noack_req_count", req_count, WDOG ? cnt_before : (cnt_before + 1) % (1 << CW));

    // Reset while a request is presented and two are queued
    force_d = 20; force_h = 1;
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10 && !eql; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_eql", eql, 0);
    chk("midrst_busy", busy, 0);
    repeat (30) step(1'b0, 1'b0, 1'b0);

    // Counter wrap: five completions with a 2-bit counter
    force_d = 1; force_h = 1;
    repeat (5) step(1'b1, 1'b1, 1'b0);
    drain();
    chk("wrap_req_count", req_count, 1);

    // Randomised traffic with random responder behaviour
    force_d = -9;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)), 1'b0);
    drain();
    chk("final_all_served", q.size() + rise_q.size() + out_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
